// File: rtl/interrupt_ctrl_pkg.sv
// Shared definitions for the interrupt controller: system register map, PCS bit positions, FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package interrupt_ctrl_pkg;

    // System register indices as seen on sysRegAddr
    localparam logic [3:0] SR_PCS = 4'd0;
    localparam logic [3:0] SR_IHA = 4'd1;
    localparam logic [3:0] SR_IRA = 4'd2;
    localparam logic [3:0] SR_IDN = 4'd3;
    localparam logic [3:0] SR_IMR = 4'd4;

    // Bit positions inside PCS
    localparam int PCS_IE  = 0;
    localparam int PCS_OIE = 1;

    // Decoder pcSel value that selects intaAddr (interrupt entry / RETI)
    localparam logic [1:0] PCSEL_INTA = 2'b11;

    // Interrupt sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/interrupt_ctrl_prio_enc.sv
// Fixed-priority encoder for interrupt requests; bit 0 wins.
// Latency: purely combinational.
// Backpressure: none; outputs follow the request vector in the same cycle.
module irq_prio_enc #(
    parameter int NUM_DEV = 4
) (
    input  logic [NUM_DEV-1:0] req,
    output logic               any,
    output logic [3:0]         index,
    output logic [NUM_DEV-1:0] onehot
);

    // Scan upward from bit 0; the first set bit is the winner
    always_comb begin
        logic found;
        found  = 1'b0;
        any    = |req;
        index  = 4'd0;
        onehot = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (req[i] && !found) begin
                found     = 1'b1;
                index     = i[3:0];
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// System registers (PCS/IHA/IRA/IDN[/IMR]) and interrupt entry/return sequencing for the decoder.
// Latency: request sampled in cycle N gives intaSig/irqAck in N+1; RSR data and intaAddr are combinational.
// Backpressure: stall or any decoder strobe holds off interrupt entry; optional IMR via IRQ_MASK_EN.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int               DBITS     = 32,
    parameter int               NUM_DEV   = 4,
    parameter logic [DBITS-1:0] RESET_IHA = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DEV-1:0] irqIn,
    input  logic [DBITS-1:0]   pcIn,
    input  logic               stall,
    input  logic               isReti,
    input  logic               isRSR,
    input  logic               isWSR,
    input  logic [3:0]         sysRegAddr,
    input  logic [DBITS-1:0]   sysDataIn,
    output logic               intaSig,
    output logic [DBITS-1:0]   intaAddr,
    output logic [DBITS-1:0]   sysDataOut1,
    output logic [NUM_DEV-1:0] irqAck,
    output logic               inService
);

    irq_state_e         state_q;
    irq_state_e         state_d;
    logic               ie_q;
    logic               oie_q;
    logic [DBITS-1:0]   iha_q;
    logic [DBITS-1:0]   ira_q;
    logic [3:0]         idn_q;
    logic               inta_q;
    logic [NUM_DEV-1:0] ack_q;

    logic [NUM_DEV-1:0] pending;
    logic               pend_any;
    logic [3:0]         pend_idx;
    logic [NUM_DEV-1:0] pend_onehot;
    logic               take;
    logic               wr_en;

`ifdef IRQ_MASK_EN
    logic [NUM_DEV-1:0] imr_q;
    assign pending = irqIn & imr_q;
`else
    assign pending = irqIn;
`endif

    irq_prio_enc #(
        .NUM_DEV (NUM_DEV)
    ) u_prio (
        .req    (pending),
        .any    (pend_any),
        .index  (pend_idx),
        .onehot (pend_onehot)
    );

    // Entry is only allowed when the pipeline is free of any decoder side effect this cycle
    assign take = ie_q & pend_any & ~stall & ~isReti & ~isRSR & ~isWSR & (state_q != ST_ACK);

    // The entry update owns the registers during the ACK cycle, so software writes are dropped there
    assign wr_en = isWSR & (state_q != ST_ACK);

    // Next-state selection for the entry/service/return sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (take) begin
                    state_d = ST_ACK;
                end else if (isReti) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry pulse, acknowledge and system register updates (entry, then WSR, then RETI restore of IE)
    always_ff @(posedge clk) begin
        if (reset) begin
            inta_q <= 1'b0;
            ack_q  <= '0;
            ie_q   <= 1'b0;
            oie_q  <= 1'b0;
            iha_q  <= RESET_IHA;
            ira_q  <= '0;
            idn_q  <= 4'd0;
`ifdef IRQ_MASK_EN
            imr_q  <= '1;
`endif
        end else begin
            inta_q <= take;
            ack_q  <= take ? pend_onehot : '0;
            if (take) begin
                idn_q <= pend_idx;
                oie_q <= ie_q;
                ie_q  <= 1'b0;
                ira_q <= pcIn;
            end else begin
                if (wr_en) begin
                    case (sysRegAddr)
                        SR_PCS: begin
                            ie_q  <= sysDataIn[PCS_IE];
                            oie_q <= sysDataIn[PCS_OIE];
                        end
                        SR_IHA: iha_q <= sysDataIn;
                        SR_IRA: ira_q <= sysDataIn;
                        SR_IDN: idn_q <= sysDataIn[3:0];
`ifdef IRQ_MASK_EN
                        SR_IMR: imr_q <= sysDataIn[NUM_DEV-1:0];
`endif
                        default: ;
                    endcase
                end
                // RETI restores IE from the saved copy in any state
                if (isReti) begin
                    ie_q <= oie_q;
                end
            end
        end
    end

    // Handler address during entry, return address otherwise (RETI target)
    always_comb begin
        intaAddr = (state_q == ST_ACK) ? iha_q : ira_q;
    end

    // RSR read mux, pre-edge register values
    always_comb begin
        sysDataOut1 = '0;
        case (sysRegAddr)
            SR_PCS: begin
                sysDataOut1[PCS_IE]  = ie_q;
                sysDataOut1[PCS_OIE] = oie_q;
            end
            SR_IHA: sysDataOut1 = iha_q;
            SR_IRA: sysDataOut1 = ira_q;
            SR_IDN: sysDataOut1 = DBITS'(idn_q);
`ifdef IRQ_MASK_EN
            SR_IMR: sysDataOut1 = DBITS'(imr_q);
`endif
            default: sysDataOut1 = '0;
        endcase
    end

    assign intaSig   = inta_q;
    assign irqAck    = ack_q;
    assign inService = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Testbench for interrupt_ctrl: directed scenarios plus randomized run against a behavioural model.
// Latency: model advances once per rising edge; outputs sampled 1-2 time units after the edge.
// Backpressure: stall and decoder strobes are exercised as entry blockers.
module tb_interrupt_ctrl;

    localparam int DBITS   = 32;
    localparam int NUM_DEV = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_DEV-1:0] irqIn;
    logic [DBITS-1:0]   pcIn;
    logic               stall;
    logic               isReti;
    logic               isRSR;
    logic               isWSR;
    logic [3:0]         sysRegAddr;
    logic [DBITS-1:0]   sysDataIn;
    logic               intaSig;
    logic [DBITS-1:0]   intaAddr;
    logic [DBITS-1:0]   sysDataOut1;
    logic [NUM_DEV-1:0] irqAck;
    logic               inService;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit                 m_ie;
    bit                 m_oie;
    logic [DBITS-1:0]   m_iha;
    logic [DBITS-1:0]   m_ira;
    logic [3:0]         m_idn;
    logic [NUM_DEV-1:0] m_imr;
    bit                 m_acking;
    bit                 m_serv;
    logic [NUM_DEV-1:0] m_ackvec;

    interrupt_ctrl #(
        .DBITS     (DBITS),
        .NUM_DEV   (NUM_DEV),
        .RESET_IHA (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irqIn       (irqIn),
        .pcIn        (pcIn),
        .stall       (stall),
        .isReti      (isReti),
        .isRSR       (isRSR),
        .isWSR       (isWSR),
        .sysRegAddr  (sysRegAddr),
        .sysDataIn   (sysDataIn),
        .intaSig     (intaSig),
        .intaAddr    (intaAddr),
        .sysDataOut1 (sysDataOut1),
        .irqAck      (irqAck),
        .inService   (inService)
    );

    always #5 clk = ~clk;

    function automatic logic [DBITS-1:0] m_read(input logic [3:0] a);
        case (a)
            4'd0: return {30'd0, m_oie, m_ie};
            4'd1: return m_iha;
            4'd2: return m_ira;
            4'd3: return 32'(m_idn);
`ifdef IRQ_MASK_EN
            4'd4: return 32'(m_imr);
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One rising edge of the reference model, using the inputs currently driven
    task automatic model_edge();
        logic [NUM_DEV-1:0] pend;
        bit                 take;
        int                 low;
        bit                 old_ack;
        bit                 old_serv;
        bit                 old_oie;
        if (reset) begin
            m_ie = 0; m_oie = 0; m_iha = 32'h100; m_ira = 0; m_idn = 0;
            m_imr = '1; m_acking = 0; m_serv = 0; m_ackvec = '0;
        end else begin
            pend = irqIn & m_imr;
            take = m_ie && (pend != 0) && !stall && !isReti && !isRSR && !isWSR && !m_acking;
            low = -1;
            for (int i = 0; i < NUM_DEV; i++) begin
                if (pend[i] && low < 0) low = i;
            end
            old_ack  = m_acking;
            old_serv = m_serv;
            old_oie  = m_oie;
            if (take) begin
                m_acking = 1; m_serv = 0;
                m_ackvec = '0; m_ackvec[low] = 1'b1;
                m_idn = low[3:0]; m_oie = m_ie; m_ie = 0; m_ira = pcIn;
            end else begin
                m_acking = 0; m_ackvec = '0;
                if (old_ack) m_serv = 1;
                else if (isReti && old_serv) m_serv = 0;
                if (isWSR && !old_ack) begin
                    case (sysRegAddr)
                        4'd0: begin m_ie = sysDataIn[0]; m_oie = sysDataIn[1]; end
                        4'd1: m_iha = sysDataIn;
                        4'd2: m_ira = sysDataIn;
                        4'd3: m_idn = sysDataIn[3:0];
`ifdef IRQ_MASK_EN
                        4'd4: m_imr = sysDataIn[NUM_DEV-1:0];
`endif
                        default: ;
                    endcase
                end
                if (isReti) m_ie = old_oie;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        stall = 0; isReti = 0; isRSR = 0; isWSR = 0;
        sysRegAddr = 4'd0; sysDataIn = '0;
    endtask

    task automatic test_reset();
        reset = 1; irqIn = '0; pcIn = '0; quiet();
        tick(); tick();
        reset = 0;
        #1;
        checks++; if (intaSig !== 1'b0) begin errors++; $display("FAIL reset_inta got=%0h exp=0", intaSig); end
        checks++; if (irqAck !== 4'h0) begin errors++; $display("FAIL reset_ack got=%0h exp=0", irqAck); end
        checks++; if (inService !== 1'b0) begin errors++; $display("FAIL reset_insvc got=%0h exp=0", inService); end
        isRSR = 1; sysRegAddr = 4'd1; #1;
        checks++; if (sysDataOut1 !== 32'h100) begin errors++; $display("FAIL reset_iha got=%h exp=00000100", sysDataOut1); end
        sysRegAddr = 4'd0; #1;
        checks++; if (sysDataOut1 !== 32'h0) begin errors++; $display("FAIL reset_pcs got=%h exp=0", sysDataOut1); end
        isRSR = 0;
        irqIn = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (intaSig !== 1'b0) begin errors++; $display("FAIL ie0_inta got=%0h exp=0", intaSig); end
        end
        irqIn = '0;
    endtask

    task automatic test_entry_and_reti();
        isWSR = 1; sysRegAddr = 4'd0; sysDataIn = 32'h1;
        tick(); quiet();
        irqIn = 4'b0110; pcIn = 32'h40; #1;
        checks++; if (intaSig !== 1'b0) begin errors++; $display("FAIL entry_pre got=%0h exp=0", intaSig); end
        tick();
        irqIn = '0;
        checks++; if (intaSig !== 1'b1) begin errors++; $display("FAIL entry_inta got=%0h exp=1", intaSig); end
        checks++; if (irqAck !== 4'b0010) begin errors++; $display("FAIL entry_ack got=%b exp=0010", irqAck); end
        checks++; if (intaAddr !== 32'h100) begin errors++; $display("FAIL entry_addr got=%h exp=00000100", intaAddr); end
        isRSR = 1; sysRegAddr = 4'd2; #1;
        checks++; if (sysDataOut1 !== 32'h40) begin errors++; $display("FAIL entry_ira got=%h exp=00000040", sysDataOut1); end
        sysRegAddr = 4'd3; #1;
        checks++; if (sysDataOut1 !== 32'h1) begin errors++; $display("FAIL entry_idn got=%h exp=1", sysDataOut1); end
        sysRegAddr = 4'd0; #1;
        checks++; if (sysDataOut1 !== 32'h2) begin errors++; $display("FAIL entry_pcs got=%h exp=2", sysDataOut1); end
        isRSR = 0;
        tick();
        checks++; if (intaSig !== 1'b0 || irqAck !== 4'h0) begin errors++; $display("FAIL pulse_width got=%0h/%b exp=0/0000", intaSig, irqAck); end
        checks++; if (inService !== 1'b1) begin errors++; $display("FAIL service got=%0h exp=1", inService); end
        isReti = 1; #1;
        checks++; if (intaAddr !== 32'h40) begin errors++; $display("FAIL reti_addr got=%h exp=00000040", intaAddr); end
        tick(); isReti = 0;
        checks++; if (inService !== 1'b0) begin errors++; $display("FAIL reti_idle got=%0h exp=0", inService); end
        isRSR = 1; sysRegAddr = 4'd0; #1;
        checks++; if (sysDataOut1 !== 32'h3) begin errors++; $display("FAIL reti_pcs got=%h exp=3", sysDataOut1); end
        isRSR = 0;
    endtask

    task automatic test_blockers();
        irqIn = 4'b0001; stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (intaSig !== 1'b0) begin errors++; $display("FAIL stall_block got=%0h exp=0", intaSig); end
        end
        stall = 0; isWSR = 1; sysRegAddr = 4'd5; sysDataIn = $urandom;
        tick();
        checks++; if (intaSig !== 1'b0) begin errors++; $display("FAIL wsr_block got=%0h exp=0", intaSig); end
        quiet();
        tick();
        checks++; if (intaSig !== 1'b1 || irqAck !== 4'b0001) begin errors++; $display("FAIL release got=%0h/%b exp=1/0001", intaSig, irqAck); end
        irqIn = '0;
        tick();
        isReti = 1; tick(); isReti = 0;
    endtask

    task automatic test_iha_write();
        isWSR = 1; sysRegAddr = 4'd1; sysDataIn = 32'h200;
        tick(); quiet();
        irqIn = 4'b1000; pcIn = 32'h88;
        tick();
        irqIn = '0;
        checks++; if (intaSig !== 1'b1 || irqAck !== 4'b1000) begin errors++; $display("FAIL iha_entry got=%0h/%b exp=1/1000", intaSig, irqAck); end
        checks++; if (intaAddr !== 32'h200) begin errors++; $display("FAIL iha_addr got=%h exp=00000200", intaAddr); end
        isWSR = 1; sysRegAddr = 4'd1; sysDataIn = 32'h300;
        tick(); quiet();
        isRSR = 1; sysRegAddr = 4'd1; #1;
        checks++; if (sysDataOut1 !== 32'h200) begin errors++; $display("FAIL ack_wsr_ignored got=%h exp=00000200", sysDataOut1); end
        isRSR = 0; isReti = 1; #1;
        checks++; if (intaAddr !== 32'h88) begin errors++; $display("FAIL iha_reti got=%h exp=00000088", intaAddr); end
        tick(); isReti = 0;
    endtask

    task automatic test_mask();
`ifdef IRQ_MASK_EN
        isWSR = 1; sysRegAddr = 4'd4; sysDataIn = 32'hE;
        tick(); quiet();
        irqIn = 4'b0011;
        tick();
        irqIn = '0;
        checks++; if (irqAck !== 4'b0010) begin errors++; $display("FAIL mask_ack got=%b exp=0010", irqAck); end
        tick();
        isReti = 1; tick(); quiet();
        isWSR = 1; sysRegAddr = 4'd4; sysDataIn = 32'hF;
        tick(); quiet();
`else
        isWSR = 1; sysRegAddr = 4'd4; sysDataIn = 32'hFFFF_FFFF;
        tick(); quiet();
        isRSR = 1; sysRegAddr = 4'd4; #1;
        checks++; if (sysDataOut1 !== 32'h0) begin errors++; $display("FAIL addr4_zero got=%h exp=0", sysDataOut1); end
        isRSR = 0;
`endif
    endtask

    task automatic test_reti_in_idle();
        isWSR = 1; sysRegAddr = 4'd0; sysDataIn = 32'h2;
        tick(); quiet();
        isReti = 1; #1;
        checks++; if (intaAddr !== 32'h88) begin errors++; $display("FAIL idle_reti_addr got=%h exp=00000088", intaAddr); end
        tick(); isReti = 0;
        isRSR = 1; sysRegAddr = 4'd0; #1;
        checks++; if (sysDataOut1 !== 32'h3) begin errors++; $display("FAIL idle_reti_pcs got=%h exp=3", sysDataOut1); end
        isRSR = 0;
    endtask

    task automatic test_reset_mid_ack();
        irqIn = 4'b0100; pcIn = 32'h1234;
        tick();
        irqIn = '0;
        checks++; if (intaSig !== 1'b1) begin errors++; $display("FAIL mid_ack_entry got=%0h exp=1", intaSig); end
        reset = 1;
        tick();
        reset = 0;
        checks++; if (intaSig !== 1'b0 || irqAck !== 4'h0 || inService !== 1'b0) begin
            errors++; $display("FAIL mid_ack_reset got=%0h/%b/%0h exp=0/0000/0", intaSig, irqAck, inService);
        end
    endtask

    task automatic test_random();
        reset = 1; quiet(); irqIn = '0; tick(); reset = 0;
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 79) == 0);
            irqIn      = 4'($urandom);
            pcIn       = $urandom;
            stall      = ($urandom_range(0, 3) == 0);
            isReti     = ($urandom_range(0, 7) == 0);
            isRSR      = ($urandom_range(0, 7) == 0);
            isWSR      = ($urandom_range(0, 5) == 0);
            sysRegAddr = 4'($urandom_range(0, 5));
            sysDataIn  = $urandom;
            #1;
            checks++; if (sysDataOut1 !== m_read(sysRegAddr)) begin errors++; $display("FAIL rnd_rsr n=%0d got=%h exp=%h", n, sysDataOut1, m_read(sysRegAddr)); end
            checks++; if (intaAddr !== (m_acking ? m_iha : m_ira)) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, intaAddr, (m_acking ? m_iha : m_ira)); end
            tick();
            checks++; if (intaSig !== m_acking) begin errors++; $display("FAIL rnd_inta n=%0d got=%0h exp=%0h", n, intaSig, m_acking); end
            checks++; if (irqAck !== m_ackvec) begin errors++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, irqAck, m_ackvec); end
            checks++; if (inService !== m_serv) begin errors++; $display("FAIL rnd_insvc n=%0d got=%0h exp=%0h", n, inService, m_serv); end
        end
        reset = 0; quiet();
    endtask

    initial begin
        test_reset();
        test_entry_and_reti();
        test_blockers();
        test_iha_write();
        test_mask();
        test_reti_in_idle();
        test_reset_mid_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- System-register and interrupt-sequencing block that pairs with the instruction decoder.
- It raises intaSig and supplies intaAddr for the decoder's interrupt/RETI PC selection (pcSel=11).
- It serves RSR reads through sysDataOut1 (decoder memOutSel=11) and absorbs WSR writes.
- It owns the PCS, IHA, IRA and IDN system registers and acknowledges the serviced device.

Parameters:
DBITS, 32, data/address width
NUM_DEV, 4, number of interrupt request lines (1..16)
RESET_IHA, 32'h0000_0100, reset value of handler address register

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
irqIn  input  NUM_DEV  level-sensitive device requests; bit 0 is highest priority
pcIn  input  DBITS  PC of the instruction being replaced; captured as the return address
stall  input  1  pipeline stall; no interrupt is taken while high
isReti  input  1  decoder RETI strobe
isRSR  input  1  decoder RSR strobe
isWSR  input  1  decoder WSR strobe
sysRegAddr  input  4  system register index (decoder s1/d field)
sysDataIn  input  DBITS  WSR write data
intaSig  output  1  interrupt-accept pulse to decoder
intaAddr  output  DBITS  target PC for interrupt entry or RETI
sysDataOut1  output  DBITS  RSR read data (combinational)
irqAck  output  NUM_DEV  one-hot acknowledge, pulses with intaSig
inService  output  1  high in SERVICE state

Behaviour:
- System register map:
  - 0 PCS: bit0 IE, bit1 OIE, other bits 0.
  - 1 IHA.
  - 2 IRA.
  - 3 IDN (zero-extended device index).
  - Other addresses read 0 and ignore writes.
- Reset:
  - State IDLE.
  - IE=0, OIE=0, IHA=RESET_IHA, IRA=0, IDN=0.
  - intaSig=0, irqAck=0, inService=0.
- FSM states IDLE, ACK, SERVICE; transitions:
  - IDLE/SERVICE -> ACK when take=1, where take = IE & |irqIn & ~stall & ~isReti & ~isRSR & ~isWSR, evaluated on registered state.
  - ACK -> SERVICE unconditionally after 1 cycle.
  - SERVICE -> IDLE on isReti.
- Entering ACK (registered at the same edge):
  - intaSig=1 and irqAck=one-hot(lowest pending index) for exactly one cycle.
  - IDN=that index.
  - OIE<=IE, IE<=0.
  - IRA<=pcIn, sampled in the take cycle.
- Latency: irq sampled at cycle N; intaSig high in cycle N+1.
- intaAddr (combinational):
  - In ACK: IHA.
  - Otherwise: IRA.
  - Valid in the RETI cycle as well as the intaSig cycle.
- RETI, any state:
  - IE<=OIE.
  - If the state is SERVICE, state <= IDLE.
  - A RETI in IDLE is still honoured: intaAddr=IRA and IE is restored.
- WSR:
  - Writes sysDataIn to the addressed register at the clock edge.
  - A PCS write updates only bits 1:0.
  - Writes are ignored in the ACK cycle, because the entry update has priority.
- RSR: sysDataOut1 = register[sysRegAddr] pre-edge, same cycle, no side effects.
- Nesting: if the handler sets IE via WSR while in SERVICE, a new request goes to ACK and overwrites IRA/OIE; software must save IRA first.
- irqIn deasserting before ACK: no interrupt is taken that cycle; the take condition is purely combinational.
- Reset mid-ACK forces IDLE; the intaSig pulse is dropped on the next cycle.

Optional Feature:
- Macro IRQ_MASK_EN.
- Defined:
  - Adds IMR at address 4, NUM_DEV bits, reset all 1 (enabled).
  - Pending = irqIn & IMR; read/write via RSR/WSR.
- Undefined:
  - Pending = irqIn; address 4 reads 0 and ignores writes.

Decomposition:
- Shared package holds:
  - sys register address constants (PCS/IHA/IRA/IDN/IMR).
  - PCS bit positions IE=0, OIE=1.
  - FSM state enum.
  - pcSel encoding constant for intaAddr (2'b11).
- One sub-module, irq_prio_enc:
  - Parameterized NUM_DEV.
  - Outputs any, index and one-hot.

Test Plan:
- Reset; RSR addr1 -> sysDataOut1=32'h100; RSR addr0 -> 0; irqIn=4'b0001 with IE=0 -> intaSig stays 0.
- WSR PCS=1; irqIn=4'b0110 at cycle N with pcIn=32'h40 -> intaSig=1 in N+1; irqAck=4'b0010; intaAddr=32'h100; IRA=32'h40; IDN=1; PCS=2'b10.
- In SERVICE, isReti -> intaAddr=32'h40 that cycle; next cycle state IDLE and PCS=2'b11.
- irqIn pending with IE=1 while stall=1 or isWSR=1 -> no intaSig; releasing the blocker -> intaSig next cycle.
- WSR IHA=32'h200 then interrupt -> intaAddr=32'h200; WSR arriving in the ACK cycle -> IHA unchanged.
- IRQ_MASK_EN: WSR IMR=4'b1110, irqIn=4'b0011 -> irqAck=4'b0010; without the macro, RSR addr4 -> 0.
